// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : edge_event_arbiter
//  Description : Per-channel edge detection with one-deep pending events,
//                sticky overflow flags and a fair round-robin valid/ready
//                event port. All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module edge_event_arbiter #(
    parameter int N  = 4,   // number of input channels (2..16)
    parameter int CW = 2    // evt_chan width, equals $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in,
    input  logic [2*N-1:0]   mode,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CW-1:0]    evt_chan,
    output logic             evt_rise,
    output logic [N-1:0]     ovf,
    input  logic [N-1:0]     ovf_clr
);

    // Index width wide enough to hold start + offset before the modulo wrap.
    localparam int IW = CW + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t            r_state;
    logic [N-1:0]      r_prev;       // last sampled level per channel
    logic [N-1:0]      r_pend;       // one-deep pending event per channel
    logic [N-1:0]      r_pol;        // polarity of the newest pending edge
    logic [N-1:0]      r_ovf;        // sticky lost-event flags
    logic [CW-1:0]     r_rr_ptr;     // round-robin search start
    logic              r_evt_valid;
    logic [CW-1:0]     r_evt_chan;
    logic              r_evt_rise;

    // ------------------------------------------------------------------------
    // Combinational next-state terms
    // ------------------------------------------------------------------------
    logic [N-1:0]      w_rise;
    logic [N-1:0]      w_fall;
    logic [N-1:0]      w_en_edge;    // edge that the channel mode accepts
    logic [N-1:0]      w_acc_vec;    // one-hot of the channel accepted this cycle
    logic [N-1:0]      w_ovf_set;
    logic [N-1:0]      w_pend_nxt;
    logic [N-1:0]      w_pol_nxt;
    logic [N-1:0]      w_ovf_nxt;
    logic              w_accept;
    logic [CW-1:0]     w_chan_inc;   // evt_chan + 1 modulo N
    logic [N-1:0]      w_srch_mask;
    logic [CW-1:0]     w_srch_start;
    logic              w_found;
    logic [CW-1:0]     w_sel;

    assign w_accept = r_evt_valid & evt_ready;

    // Per-channel edge qualification, accept decode and polarity update.
    for (genvar k = 0; k < N; k++) begin : g_chan
        assign w_rise[k]    = in[k] & ~r_prev[k];
        assign w_fall[k]    = ~in[k] & r_prev[k];
        assign w_en_edge[k] = (w_rise[k] & mode[2*k]) | (w_fall[k] & mode[2*k+1]);
        assign w_acc_vec[k] = w_accept && (r_evt_chan == CW'(k));
        assign w_pol_nxt[k] = w_en_edge[k] ? w_rise[k] : r_pol[k];
    end

    // A new edge on an already pending channel overwrites it and is flagged,
    // unless that channel is being drained in the same cycle.
    assign w_ovf_set  = w_en_edge & r_pend & ~w_acc_vec;
    assign w_pend_nxt = (r_pend & ~w_acc_vec) | w_en_edge;
    // Set has priority over clear so a simultaneous loss is never hidden.
    assign w_ovf_nxt  = (r_ovf & ~ovf_clr) | w_ovf_set;

    assign w_chan_inc = (r_evt_chan == CW'(N - 1)) ? '0 : r_evt_chan + CW'(1);

    // Search inputs: from IDLE use the stored pointer; from OFFER after an
    // accept, search the remaining pending set starting just past the winner.
    assign w_srch_mask  = (r_state == ST_OFFER) ? (r_pend & ~w_acc_vec) : r_pend;
    assign w_srch_start = (r_state == ST_OFFER) ? w_chan_inc : r_rr_ptr;

    // Round-robin pick: first set bit of the mask at or above the start, wrapping at N.
    always_comb begin
        logic [IW-1:0] idx;
        w_found = 1'b0;
        w_sel   = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, w_srch_start} + IW'(i);
            if (idx >= IW'(N)) begin
                idx = idx - IW'(N);
            end
            if (!w_found && w_srch_mask[idx[CW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = idx[CW-1:0];
            end
        end
    end

    // Channel bookkeeping: previous levels, pending bits, polarity and overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= in;
            r_pend <= '0;
            r_pol  <= '0;
            r_ovf  <= '0;
        end else begin
            r_prev <= in;
            r_pend <= w_pend_nxt;
            r_pol  <= w_pol_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    // Offer FSM: loads a frozen payload and reselects back-to-back on accept.
    // The payload polarity comes from the next-cycle polarity so an edge that
    // lands in the selection cycle is the one delivered (the older is flagged).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_evt_valid <= 1'b0;
            r_evt_chan  <= '0;
            r_evt_rise  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_evt_valid <= 1'b1;
                        r_evt_chan  <= w_sel;
                        r_evt_rise  <= w_pol_nxt[w_sel];
                        r_state     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (w_accept) begin
                        r_rr_ptr <= w_chan_inc;
                        if (w_found) begin
                            r_evt_chan <= w_sel;
                            r_evt_rise <= w_pol_nxt[w_sel];
                        end else begin
                            r_evt_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_evt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_chan  = r_evt_chan;
    assign evt_rise  = r_evt_rise;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_event_arbiter
//  Description : Directed vector bench for edge_event_arbiter (N=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sig_in;
    logic [7:0] mode;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_chan;
    logic       evt_rise;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;

    int checks   = 0;
    int failures = 0;

    edge_event_arbiter #(.N(4), .CW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (sig_in),
        .mode      (mode),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_chan  (evt_chan),
        .evt_rise  (evt_rise),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] in;
        logic [7:0] mode;
        logic       ready;
        logic [3:0] clr;
        logic       exp_valid;
        logic [1:0] exp_chan;
        logic       exp_rise;
        logic [3:0] exp_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [3:0] i, input logic [7:0] m,
                                input logic rdy, input logic [3:0] c, input logic ev,
                                input logic [1:0] ec, input logic er, input logic [3:0] eo);
        vec_t v;
        v.rst_n = r; v.in = i; v.mode = m; v.ready = rdy; v.clr = c;
        v.exp_valid = ev; v.exp_chan = ec; v.exp_rise = er; v.exp_ovf = eo;
        return v;
    endfunction

    // Drive one cycle of inputs, then sample just after the next rising edge.
    task automatic cyc(input logic r, input logic [3:0] i, input logic [7:0] m,
                       input logic rdy, input logic [3:0] c);
        rst_n = r; sig_in = i; mode = m; evt_ready = rdy; ovf_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [1:0] ec,
                           input logic er, input logic [3:0] eo, input logic pay);
        chk({nm, " valid"}, {7'd0, evt_valid}, {7'd0, ev});
        if (pay) begin
            chk({nm, " chan"}, {6'd0, evt_chan}, {6'd0, ec});
            chk({nm, " rise"}, {7'd0, evt_rise}, {7'd0, er});
        end
        chk({nm, " ovf"}, {4'd0, ovf}, {4'd0, eo});
    endtask

    initial begin
        rst_n = 1'b0; sig_in = 4'b0; mode = 8'h55; evt_ready = 1'b0; ovf_clr = 4'b0;

        // Single rising edge on ch2: offered two cycles after the edge, for one cycle.
        tbl.push_back(mk(0, 4'b0000, 8'h55, 1, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 8'h55, 1, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0100, 8'h55, 1, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0100, 8'h55, 1, 4'b0000, 1, 2, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0100, 8'h55, 1, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0100, 8'h55, 1, 4'b0000, 0, 0, 0, 4'b0000));
        // Three simultaneous rises: back-to-back 0,1,3 with valid held high.
        tbl.push_back(mk(0, 4'b0000, 8'h55, 1, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b1011, 8'h55, 1, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b1011, 8'h55, 1, 4'b0000, 1, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b1011, 8'h55, 1, 4'b0000, 1, 1, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b1011, 8'h55, 1, 4'b0000, 1, 3, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b1011, 8'h55, 1, 4'b0000, 0, 0, 0, 4'b0000));
        // ch1 both-edges, 0->1->0 with ready low: overflow, newest (fall) delivered, clear.
        tbl.push_back(mk(0, 4'b0000, 8'h5D, 0, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0010, 8'h5D, 0, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 8'h5D, 0, 4'b0000, 1, 1, 0, 4'b0010));
        tbl.push_back(mk(1, 4'b0000, 8'h5D, 0, 4'b0000, 1, 1, 0, 4'b0010));
        tbl.push_back(mk(1, 4'b0000, 8'h5D, 1, 4'b0000, 0, 0, 0, 4'b0010));
        tbl.push_back(mk(1, 4'b0000, 8'h5D, 1, 4'b0010, 0, 0, 0, 4'b0000));
        // Reset during OFFER with all levels high: drops everything, no edge after release.
        tbl.push_back(mk(0, 4'b0000, 8'h55, 0, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b1111, 8'h55, 0, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b1111, 8'h55, 0, 4'b0000, 1, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b1110, 8'h55, 0, 4'b0000, 1, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b1111, 8'h55, 0, 4'b0000, 1, 0, 1, 4'b0001));
        tbl.push_back(mk(0, 4'b1111, 8'h55, 0, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b1111, 8'h55, 1, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b1111, 8'h55, 1, 4'b0000, 0, 0, 0, 4'b0000));
        // Accept ch2 while ch2 sees a new rise: re-offered later, no overflow.
        tbl.push_back(mk(0, 4'b0000, 8'h55, 0, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0100, 8'h55, 0, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 8'h55, 0, 4'b0000, 1, 2, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0100, 8'h55, 1, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0100, 8'h55, 1, 4'b0000, 1, 2, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0100, 8'h55, 1, 4'b0000, 0, 0, 0, 4'b0000));
        // Switching a channel off keeps its pending event; edges in off mode are ignored.
        tbl.push_back(mk(0, 4'b0000, 8'h55, 0, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0001, 8'h55, 0, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0001, 8'h00, 0, 4'b0000, 1, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0011, 8'h00, 1, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0011, 8'h00, 1, 4'b0000, 0, 0, 0, 4'b0000));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst_n, tbl[i].in, tbl[i].mode, tbl[i].ready, tbl[i].clr);
            chk_out($sformatf("row%0d", i), tbl[i].exp_valid, tbl[i].exp_chan,
                    tbl[i].exp_rise, tbl[i].exp_ovf, tbl[i].exp_valid | ~tbl[i].rst_n);
        end

        // Fairness: every channel toggles each cycle in both-edge mode, ready high.
        cyc(0, 4'b0000, 8'hFF, 1, 4'b0000); chk_out("rr reset", 0, 0, 0, 4'b0000, 1);
        cyc(1, 4'b1111, 8'hFF, 1, 4'b0000); chk_out("rr pend",  0, 0, 0, 4'b0000, 0);
        cyc(1, 4'b0000, 8'hFF, 1, 4'b0000); chk_out("rr g0",    1, 0, 0, 4'b1111, 1);
        cyc(1, 4'b1111, 8'hFF, 1, 4'b0000); chk_out("rr g1",    1, 1, 1, 4'b1111, 1);
        cyc(1, 4'b0000, 8'hFF, 1, 4'b0000); chk_out("rr g2",    1, 2, 0, 4'b1111, 1);
        cyc(1, 4'b1111, 8'hFF, 1, 4'b0000); chk_out("rr g3",    1, 3, 1, 4'b1111, 1);
        cyc(1, 4'b0000, 8'hFF, 1, 4'b0000); chk_out("rr g0b",   1, 0, 0, 4'b1111, 1);
        // Ready low for three cycles: payload frozen; clear loses to a new overflow.
        cyc(1, 4'b1111, 8'hFF, 0, 4'b1111); chk_out("hold1",    1, 0, 0, 4'b1111, 1);
        cyc(1, 4'b1111, 8'hFF, 0, 4'b1111); chk_out("hold2",    1, 0, 0, 4'b0000, 1);
        cyc(1, 4'b1111, 8'hFF, 0, 4'b0000); chk_out("hold3",    1, 0, 0, 4'b0000, 1);
        cyc(1, 4'b1111, 8'hFF, 1, 4'b0000); chk_out("rr g1b",   1, 1, 1, 4'b0000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
